// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR tap sequencer: FSM encoding, width helpers
// and the parameter legality rule used by the top level.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DUMP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A single channel still needs a one-bit ch_sel port.
  function automatic int ch_width(input int nch);
    return (nch < 2) ? 1 : clog2(nch);
  endfunction

  function automatic bit params_ok(input int ntaps, input int nch, input int max_smp,
                                   input int tap_w, input int ch_w, input int smp_w);
    return (ntaps >= 2) && (nch >= 1) && ((1 << tap_w) >= ntaps) &&
           (ch_w == ch_width(nch)) && ((1 << smp_w) > max_smp);
  endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Modulo-N up counter with clear priority and a terminal-count flag;
// used for both the tap index and the channel index.
module fir_tap_counter #(
  parameter int N = 11,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         GlobalReset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign tc = (count == LAST);

  // NOTE: the reset edge is in the sensitivity list so the counter clears
  // without waiting for a clock; state is updated with <= only.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset)  count <= '0;
    else if (clr)     count <= '0;
    else if (inc)     count <= tc ? '0 : count + W'(1);
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Control FSM for a shared-MAC FIR: steps taps and channels per accepted
// sample, drives accumulator clear/enable and flags results, overrun and frame end.
module fir_tap_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS   = 11,
  parameter int NCH     = 1,
  parameter int MAX_SMP = 20,
  parameter int TAP_W   = 4,
  parameter int CH_W    = 1,
  parameter int SMP_W   = 5
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             srdyi,
  input  logic             global_srdyi,
  output logic [TAP_W-1:0] coeff_sel,
  output logic [CH_W-1:0]  ch_sel,
  output logic             sum_en,
  output logic             sum_rst,
  output logic             srdyo,
  output logic [CH_W-1:0]  ch_out,
  output logic             busy,
  output logic             overrun,
  output logic [SMP_W-1:0] sample_cnt,
  output logic             frame_done
);

  if (!params_ok(NTAPS, NCH, MAX_SMP, TAP_W, CH_W, SMP_W)) begin : g_bad_params
    $error("fir_tap_sequencer: illegal parameter combination");
  end

  localparam logic [SMP_W-1:0] MAX_CNT = SMP_W'(MAX_SMP);
  localparam logic [SMP_W-1:0] SMP_ONE = SMP_W'(1);

  state_t state;
  logic   tap_tc, ch_tc;
  logic   accept, drop, last_smp;
  logic   tap_clr, tap_inc, ch_clr, ch_inc;

  // A frame-start strobe releases HALT in the same cycle a sample arrives.
  assign accept   = srdyi && ((state == ST_IDLE) || ((state == ST_HALT) && global_srdyi));
  assign drop     = srdyi && !accept;
  assign last_smp = (MAX_SMP != 0) && (sample_cnt == MAX_CNT);

  assign tap_clr = accept || ((state == ST_DUMP) && !ch_tc);
  assign tap_inc = (state == ST_ACC) && !tap_tc;
  assign ch_clr  = accept;
  assign ch_inc  = (state == ST_DUMP) && !ch_tc;

  fir_tap_counter #(.N(NTAPS), .W(TAP_W)) u_tap_cnt (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .clr         (tap_clr),
    .inc         (tap_inc),
    .count       (coeff_sel),
    .tc          (tap_tc)
  );

  fir_tap_counter #(.N(NCH), .W(CH_W)) u_ch_cnt (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .clr         (ch_clr),
    .inc         (ch_inc),
    .count       (ch_sel),
    .tc          (ch_tc)
  );

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state      <= ST_IDLE;
      sum_en     <= 1'b0;
      sum_rst    <= 1'b0;
      srdyo      <= 1'b0;
      ch_out     <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      sample_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      sum_rst    <= 1'b0;
      srdyo      <= 1'b0;
      frame_done <= 1'b0;

      if (accept)            sample_cnt <= global_srdyi ? SMP_ONE :
                                           (sample_cnt == '1) ? sample_cnt : sample_cnt + SMP_ONE;
      else if (global_srdyi) sample_cnt <= '0;

      // A sample dropped in the same cycle as a frame start still counts as overrun.
      if (drop)              overrun <= 1'b1;
      else if (global_srdyi) overrun <= 1'b0;

      case (state)
        ST_IDLE, ST_HALT: begin
          if (accept) begin
            state   <= ST_ACC;
            sum_en  <= 1'b1;
            sum_rst <= 1'b1;
            busy    <= 1'b1;
          end else if ((state == ST_HALT) && global_srdyi) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_ACC: begin
          if (tap_tc) begin
            state  <= ST_DUMP;
            sum_en <= 1'b0;
            srdyo  <= 1'b1;
            ch_out <= ch_sel;
          end
        end
        ST_DUMP: begin
          if (!ch_tc) begin
            state   <= ST_ACC;
            sum_en  <= 1'b1;
            sum_rst <= 1'b1;
          end else if (last_smp) begin
            frame_done <= 1'b1;
            state      <= global_srdyi ? ST_IDLE : ST_HALT;
            busy       <= !global_srdyi;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench: a cycle-tagged event model of the sequencer predicts taps,
// results, frame ends and status; a negedge monitor pops and compares.
module tb_fir_tap_sequencer;

  localparam int NTAPS   = 11;
  localparam int NCH     = 2;
  localparam int MAX_SMP = 20;
  localparam int TAP_W   = 4;
  localparam int CH_W    = 1;
  localparam int SMP_W   = 5;
  localparam int PER     = NTAPS + 1;
  localparam int SMP_SAT = (1 << SMP_W) - 1;

  logic             clk = 1'b0;
  logic             GlobalReset = 1'b0;
  logic             srdyi = 1'b0;
  logic             global_srdyi = 1'b0;
  logic [TAP_W-1:0] coeff_sel;
  logic [CH_W-1:0]  ch_sel;
  logic             sum_en, sum_rst, srdyo;
  logic [CH_W-1:0]  ch_out;
  logic             busy, overrun;
  logic [SMP_W-1:0] sample_cnt;
  logic             frame_done;

  fir_tap_sequencer #(
    .NTAPS(NTAPS), .NCH(NCH), .MAX_SMP(MAX_SMP),
    .TAP_W(TAP_W), .CH_W(CH_W), .SMP_W(SMP_W)
  ) dut (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .srdyi        (srdyi),
    .global_srdyi (global_srdyi),
    .coeff_sel    (coeff_sel),
    .ch_sel       (ch_sel),
    .sum_en       (sum_en),
    .sum_rst      (sum_rst),
    .srdyo        (srdyo),
    .ch_out       (ch_out),
    .busy         (busy),
    .overrun      (overrun),
    .sample_cnt   (sample_cnt),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int cyc;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t st_q[$];
  ev_t tap_q[$];
  ev_t out_q[$];
  int  fd_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: last busy cycle of the current sample, halt, count, overrun.
  int m_busy_end = -1;
  bit m_halted   = 1'b0;
  int m_cnt      = 0;
  bit m_ovr      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  fc;
    if (!GlobalReset) begin
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
        e = st_q.pop_front();
        check("sample_cnt", 64'(sample_cnt), 64'(e.a));
        check("overrun", 64'(overrun), 64'(e.b));
        check("busy", 64'(busy), 64'(e.c));
      end
      if (sum_en) begin
        if (tap_q.size() == 0) check("sum_en_unexpected", 64'(sum_en), 64'd0);
        else begin
          e = tap_q.pop_front();
          check("tap_cycle", 64'(cyc), 64'(e.cyc));
          check("coeff_sel", 64'(coeff_sel), 64'(e.a));
          check("ch_sel", 64'(ch_sel), 64'(e.b));
          check("sum_rst", 64'(sum_rst), 64'(e.c));
        end
      end else begin
        if (sum_rst) check("sum_rst_without_en", 64'(sum_rst), 64'd0);
        if (tap_q.size() > 0 && tap_q[0].cyc <= cyc) begin
          check("tap_missing", 64'(sum_en), 64'd1);
          void'(tap_q.pop_front());
        end
      end
      if (srdyo) begin
        if (out_q.size() == 0) check("srdyo_unexpected", 64'(srdyo), 64'd0);
        else begin
          e = out_q.pop_front();
          check("srdyo_cycle", 64'(cyc), 64'(e.cyc));
          check("ch_out", 64'(ch_out), 64'(e.a));
        end
      end else if (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
        check("srdyo_missing", 64'(srdyo), 64'd1);
        void'(out_q.pop_front());
      end
      if (frame_done) begin
        if (fd_q.size() == 0) check("frame_done_unexpected", 64'(frame_done), 64'd0);
        else begin
          fc = fd_q.pop_front();
          check("frame_done_cycle", 64'(cyc), 64'(fc));
        end
      end else if (fd_q.size() > 0 && fd_q[0] <= cyc) begin
        check("frame_done_missing", 64'(frame_done), 64'd1);
        void'(fd_q.pop_front());
      end
    end
  end

  task automatic apply_reset();
    GlobalReset  = 1'b1;
    srdyi        = 1'b0;
    global_srdyi = 1'b0;
    st_q.delete();
    tap_q.delete();
    out_q.delete();
    fd_q.delete();
    m_busy_end = -1;
    m_halted   = 1'b0;
    m_cnt      = 0;
    m_ovr      = 1'b0;
    #1;
    check("reset_outputs", 64'({coeff_sel, ch_sel, sum_en, sum_rst, srdyo, ch_out,
                                busy, overrun, sample_cnt, frame_done}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    GlobalReset = 1'b0;
  endtask

  // Drives one cycle of inputs and records what the sequencer must do in response.
  task automatic step(input bit s, input bit g);
    int c;
    bit in_busy, halted_now, acc;
    c          = cyc;
    in_busy    = (c <= m_busy_end);
    halted_now = m_halted;
    srdyi        = s;
    global_srdyi = g;
    if (c == m_busy_end && m_cnt == MAX_SMP) begin
      fd_q.push_back(c + 1);
      if (!g) m_halted = 1'b1;
    end
    acc = s && !in_busy && (!halted_now || g);
    if (g) m_ovr = 1'b0;
    if (s && !acc) m_ovr = 1'b1;
    if (acc) m_cnt = g ? 1 : ((m_cnt < SMP_SAT) ? m_cnt + 1 : m_cnt);
    else if (g) m_cnt = 0;
    if (g && halted_now) m_halted = 1'b0;
    if (acc) begin
      m_busy_end = c + NCH * PER;
      for (int k = 0; k < NCH; k++) begin
        for (int j = 0; j < NTAPS; j++)
          tap_q.push_back('{c + k * PER + 1 + j, j, k, int'(j == 0)});
        out_q.push_back('{c + (k + 1) * PER, k, 0, 0});
      end
    end
    st_q.push_back('{c + 1, m_cnt, int'(m_ovr), int'((c + 1 <= m_busy_end) || m_halted)});
    @(posedge clk);
    #1;
    srdyi        = 1'b0;
    global_srdyi = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic send_spaced();
    step(1'b1, 1'b0);
    idle(NCH * PER);
  endtask

  task automatic fill_until(input int target);
    for (int i = 0; i < 64 && m_cnt < target; i++) send_spaced();
  endtask

  task automatic run_to_halt();
    for (int i = 0; i < 64 && !m_halted; i++) send_spaced();
  endtask

  initial begin
    #2;
    apply_reset();

    // Single sample, both channels.
    send_spaced();
    idle(3);

    // Second srdyi five cycles into the sequence is dropped.
    step(1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0);
    idle(NCH * PER + 3);

    // Fill the frame, poke while halted, then release with a frame start.
    run_to_halt();
    idle(2);
    step(1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    idle(NCH * PER + 2);

    // Frame start together with a sample while idle.
    step(1'b1, 1'b1);
    idle(NCH * PER + 2);

    // Frame start coinciding with the final result of the frame.
    fill_until(MAX_SMP - 1);
    step(1'b1, 1'b0);
    while (cyc < m_busy_end) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    idle(3);

    // Frame start together with a sample while halted.
    run_to_halt();
    idle(2);
    step(1'b1, 1'b1);
    idle(NCH * PER + 2);

    // Reset in the middle of accumulation, then a clean restart.
    step(1'b1, 1'b0);
    for (int i = 0; i < 20 && coeff_sel !== TAP_W'(5); i++) step(1'b0, 1'b0);
    check("reached_tap5", 64'(coeff_sel), 64'd5);
    #2;
    apply_reset();
    idle(NCH * PER + 2);
    send_spaced();

    // Random traffic with occasional frame starts.
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 13) == 0, $urandom_range(0, 119) == 0);
    idle(NCH * PER + 4);

    check("srdyo_queue_drained", 64'(out_q.size()), 64'd0);
    check("tap_queue_drained", 64'(tap_q.size()), 64'd0);
    check("frame_queue_drained", 64'(fd_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
